// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default 640x480@60 timing constants and colour types for vga_timing
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam bit VGA_H_POL    = 1'b0;
    localparam bit VGA_V_POL    = 1'b0;
    localparam int VGA_PIPE     = 2;

    localparam int H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int X_W = 10;
    localparam int Y_W = 10;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } rgb333_t;

    function automatic rgb333_t blank_rgb(input logic de, input rgb333_t c);
        return de ? c : '0;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - pixel request / colour return bus between timing generator and pixel source
interface vga_timing_if;
    import vga_pkg::*;

    logic           req;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           frame_start;
    logic           line_start;
    logic [2:0]     r_in;
    logic [2:0]     g_in;
    logic [2:0]     b_in;

    modport master (
        output req, x, y, frame_start, line_start,
        input  r_in, g_in, b_in
    );

    modport slave (
        input  req, x, y, frame_start, line_start,
        output r_in, g_in, b_in
    );

endinterface

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - parameterised shift register with asynchronous active-low clear
module sync_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA timing generator: wrapping counters, pixel requests, aligned blanked colour and sync pins
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit H_POL    = VGA_H_POL,
    parameter bit V_POL    = VGA_V_POL,
    parameter int PIPE     = VGA_PIPE
) (
    input  logic                clk,
    input  logic                n_rst,
    vga_timing_if.master        pix,
    output logic                hsync,
    output logic                vsync,
    output logic [2:0]          red,
    output logic [2:0]          green,
    output logic [2:0]          blue
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [X_W-1:0] HC_LAST = X_W'(H_TOT - 1);
    localparam logic [X_W-1:0] HA      = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] HS_ON   = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HS_OFF  = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] VC_LAST = Y_W'(V_TOT - 1);
    localparam logic [Y_W-1:0] VA      = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] VS_ON   = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VS_OFF  = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [X_W-1:0] hc;
    logic [Y_W-1:0] vc;
    logic           active;
    logic           hs_q, vs_q;
    logic           de_d, hs_d, vs_d;
    rgb333_t        pix_rgb, pin_rgb;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == HC_LAST) begin
            hc <= '0;
            vc <= (vc == VC_LAST) ? '0 : vc + 1'b1;
        end else begin
            hc <= hc + 1'b1;
        end
    end

    assign active = (hc < HA) && (vc < VA);

    // Request stage: sync flags are registered alongside req so all three share one delay line.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pix.req         <= 1'b0;
            pix.x           <= '0;
            pix.y           <= '0;
            pix.frame_start <= 1'b0;
            pix.line_start  <= 1'b0;
            hs_q            <= 1'b0;
            vs_q            <= 1'b0;
        end else begin
            pix.req         <= active;
            pix.x           <= active ? hc : '0;
            pix.y           <= active ? vc : '0;
            pix.frame_start <= (hc == '0) && (vc == '0);
            pix.line_start  <= (hc == '0) && (vc < VA);
            hs_q            <= (hc >= HS_ON) && (hc < HS_OFF);
            vs_q            <= (vc >= VS_ON) && (vc < VS_OFF);
        end
    end

    sync_delay #(
        .DEPTH (PIPE),
        .WIDTH (3)
    ) u_sync_delay (
        .clk   (clk),
        .n_rst (n_rst),
        .d     ({pix.req, hs_q, vs_q}),
        .q     ({de_d, hs_d, vs_d})
    );

    assign pix_rgb = {pix.r_in, pix.g_in, pix.b_in};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pin_rgb <= '0;
            hsync   <= ~H_POL;
            vsync   <= ~V_POL;
        end else begin
            pin_rgb <= blank_rgb(de_d, pix_rgb);
            hsync   <= hs_d ^ ~H_POL;
            vsync   <= vs_d ^ ~V_POL;
        end
    end

    assign red   = pin_rgb.r;
    assign green = pin_rgb.g;
    assign blue  = pin_rgb.b;

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - directed self-checking bench for vga_timing
module tb_vga_timing;

    logic clk;
    logic rst_a, rst_b, rst_c;
    int   checks;
    int   errors;

    logic       hs_a, vs_a, hs_b, vs_b, hs_c, vs_c;
    logic [2:0] red_a, green_a, blue_a;
    logic [2:0] red_b, green_b, blue_b;
    logic [2:0] red_c, green_c, blue_c;
    logic [2:0] src_a0, src_a1;

    vga_timing_if ifa ();
    vga_timing_if ifb ();
    vga_timing_if ifc ();

    // Full-size 640x480 timing, PIPE=2
    vga_timing dut_a (
        .clk (clk), .n_rst (rst_a), .pix (ifa.master),
        .hsync (hs_a), .vsync (vs_a), .red (red_a), .green (green_a), .blue (blue_a)
    );

    // Miniature timing 32x15 total, PIPE=2
    vga_timing #(
        .H_ACTIVE (16), .H_FP (4), .H_SYNC (6), .H_BP (6),
        .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (3),
        .H_POL (1'b0), .V_POL (1'b0), .PIPE (2)
    ) dut_b (
        .clk (clk), .n_rst (rst_b), .pix (ifb.master),
        .hsync (hs_b), .vsync (vs_b), .red (red_b), .green (green_b), .blue (blue_b)
    );

    // Miniature timing, PIPE=0, positive sync
    vga_timing #(
        .H_ACTIVE (16), .H_FP (4), .H_SYNC (6), .H_BP (6),
        .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (3),
        .H_POL (1'b1), .V_POL (1'b1), .PIPE (0)
    ) dut_c (
        .clk (clk), .n_rst (rst_c), .pix (ifc.master),
        .hsync (hs_c), .vsync (vs_c), .red (red_c), .green (green_c), .blue (blue_c)
    );

    always #5 clk = ~clk;

    // Pixel source models with PIPE-cycle latency
    always @(posedge clk) begin
        src_a0 <= ifa.x[2:0];
        src_a1 <= src_a0;
    end
    assign ifa.r_in = src_a1;
    assign ifa.g_in = 3'd0;
    assign ifa.b_in = 3'd5;

    assign ifb.r_in = 3'b111;
    assign ifb.g_in = 3'b111;
    assign ifb.b_in = 3'b111;

    assign ifc.r_in = ifc.x[2:0];
    assign ifc.g_in = ifc.y[2:0];
    assign ifc.b_in = 3'd3;

    task automatic test_reset();
        logic [33:0] got;
        rst_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            got = {ifa.req, ifa.frame_start, ifa.line_start, ifa.x, ifa.y,
                   red_a, green_a, blue_a, hs_a, vs_a};
            checks++;
            if (got !== {1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL reset_state cyc %0d got %h want %h", i, got,
                         {1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 9'd0, 1'b1, 1'b1});
            end
        end
    endtask

    task automatic test_line_a();
        int k, o, h, v, oh, first_low;
        logic ereq, ehs;
        logic [9:0] ex;
        logic [2:0] er, eb;
        first_low = -1;
        @(negedge clk) rst_a = 1'b1;
        for (int n = 1; n <= 1604; n++) begin
            @(posedge clk); #1;
            k = n - 1; h = k % 800; v = k / 800;
            ereq = (h < 640) && (v < 480);
            ex = ereq ? 10'(h) : 10'd0;
            checks++;
            if ({ifa.req, ifa.x, ifa.frame_start, ifa.line_start} !== {ereq, ex, n == 1, h == 0}) begin
                errors++;
                $display("FAIL a_request n=%0d got req=%b x=%0d fs=%b ls=%b want req=%b x=%0d fs=%b ls=%b",
                         n, ifa.req, ifa.x, ifa.frame_start, ifa.line_start, ereq, ex, n == 1, h == 0);
            end
            o = n - 4; oh = (o >= 0) ? o % 800 : 0;
            er  = (o >= 0 && oh < 640) ? 3'(oh % 8) : 3'd0;
            eb  = (o >= 0 && oh < 640) ? 3'd5 : 3'd0;
            ehs = !(o >= 0 && oh >= 656 && oh < 752);
            checks++;
            if ({red_a, green_a, blue_a, hs_a, vs_a} !== {er, 3'd0, eb, ehs, 1'b1}) begin
                errors++;
                $display("FAIL a_pins n=%0d got r=%0d g=%0d b=%0d hs=%b vs=%b want r=%0d g=0 b=%0d hs=%b vs=1",
                         n, red_a, green_a, blue_a, hs_a, vs_a, er, eb, ehs);
            end
            if (hs_a === 1'b0 && first_low < 0) first_low = n;
        end
        checks++;
        if (first_low != 660) begin
            errors++;
            $display("FAIL a_hsync_first_low got %0d want 660", first_low);
        end
    endtask

    task automatic test_frame_b();
        int k, o, h, v, oh, ov;
        int fs_first, fs_second, ls_cnt, vs_low, vs_first, lit;
        logic ereq, vis, ehs, evs;
        logic [9:0] ex, ey;
        fs_first = -1; fs_second = -1; ls_cnt = 0; vs_low = 0; vs_first = -1; lit = 0;
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ifb.req, red_b, green_b, blue_b, hs_b, vs_b} !== {1'b0, 9'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL b_reset got %h want %h", {ifb.req, red_b, green_b, blue_b, hs_b, vs_b},
                     {1'b0, 9'd0, 1'b1, 1'b1});
        end
        @(negedge clk) rst_b = 1'b1;
        for (int n = 1; n <= 970; n++) begin
            @(posedge clk); #1;
            k = n - 1; h = k % 32; v = (k / 32) % 15;
            ereq = (h < 16) && (v < 8);
            ex = ereq ? 10'(h) : 10'd0;
            ey = ereq ? 10'(v) : 10'd0;
            checks++;
            if ({ifb.req, ifb.x, ifb.y, ifb.frame_start, ifb.line_start} !==
                {ereq, ex, ey, (h == 0) && (v == 0), (h == 0) && (v < 8)}) begin
                errors++;
                $display("FAIL b_request n=%0d got req=%b x=%0d y=%0d fs=%b ls=%b want req=%b x=%0d y=%0d",
                         n, ifb.req, ifb.x, ifb.y, ifb.frame_start, ifb.line_start, ereq, ex, ey);
            end
            o = n - 4; oh = (o >= 0) ? o % 32 : 0; ov = (o >= 0) ? (o / 32) % 15 : 0;
            vis = (o >= 0) && (oh < 16) && (ov < 8);
            ehs = !((o >= 0) && (oh >= 20) && (oh < 26));
            evs = !((o >= 0) && (ov >= 10) && (ov < 12));
            checks++;
            if ({red_b, green_b, blue_b, hs_b, vs_b} !== {vis ? 9'h1ff : 9'h000, ehs, evs}) begin
                errors++;
                $display("FAIL b_pins n=%0d got rgb=%h hs=%b vs=%b want rgb=%h hs=%b vs=%b",
                         n, {red_b, green_b, blue_b}, hs_b, vs_b, vis ? 9'h1ff : 9'h000, ehs, evs);
            end
            if (ifb.frame_start === 1'b1) begin
                if (fs_first < 0) fs_first = n;
                else if (fs_second < 0) fs_second = n;
            end
            if (k < 480 && ifb.line_start === 1'b1) ls_cnt++;
            if (o >= 0 && o < 480) begin
                if (vs_b === 1'b0) begin
                    vs_low++;
                    if (vs_first < 0) vs_first = n;
                end
                if (red_b !== 3'd0) lit++;
            end
        end
        checks++;
        if (fs_first != 1 || fs_second - fs_first != 480) begin
            errors++;
            $display("FAIL b_frame_period got first=%0d second=%0d want 1 481", fs_first, fs_second);
        end
        checks++;
        if (ls_cnt != 8) begin
            errors++;
            $display("FAIL b_line_starts got %0d want 8", ls_cnt);
        end
        checks++;
        if (vs_low != 64 || vs_first != 324) begin
            errors++;
            $display("FAIL b_vsync got len=%0d first=%0d want len=64 first=324", vs_low, vs_first);
        end
        checks++;
        if (lit != 128) begin
            errors++;
            $display("FAIL b_lit_count got %0d want 128", lit);
        end
    endtask

    task automatic test_mid_reset_b();
        int fs_cnt, fs_last, o, oh;
        logic ehs;
        fs_cnt = 0; fs_last = -1;
        @(negedge clk) rst_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_b = 1'b1;
        repeat (173) @(posedge clk);
        #1;
        checks++;
        if ({ifb.req, ifb.x, ifb.y, red_b} !== {1'b1, 10'd12, 10'd5, 3'd7}) begin
            errors++;
            $display("FAIL b_pre_reset got req=%b x=%0d y=%0d r=%0d want 1 12 5 7",
                     ifb.req, ifb.x, ifb.y, red_b);
        end
        #2 rst_b = 1'b0;
        #1;
        checks++;
        if ({ifb.req, ifb.x, ifb.y, ifb.frame_start, ifb.line_start, red_b, green_b, blue_b, hs_b, vs_b} !==
            {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 9'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL b_async_reset got req=%b x=%0d y=%0d rgb=%h hs=%b vs=%b",
                     ifb.req, ifb.x, ifb.y, {red_b, green_b, blue_b}, hs_b, vs_b);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_b = 1'b1;
        for (int n = 1; n <= 490; n++) begin
            @(posedge clk); #1;
            if (ifb.frame_start === 1'b1) begin
                fs_cnt++;
                fs_last = n;
                checks++;
                if ({ifb.req, ifb.x, ifb.y} !== {1'b1, 10'd0, 10'd0}) begin
                    errors++;
                    $display("FAIL b_restart_origin n=%0d got req=%b x=%0d y=%0d want 1 0 0",
                             n, ifb.req, ifb.x, ifb.y);
                end
            end
            o = n - 4; oh = (o >= 0) ? o % 32 : 0;
            ehs = !((o >= 0) && (oh >= 20) && (oh < 26));
            checks++;
            if (hs_b !== ehs) begin
                errors++;
                $display("FAIL b_restart_hsync n=%0d got %b want %b", n, hs_b, ehs);
            end
        end
        checks++;
        if (fs_cnt != 2 || fs_last != 481) begin
            errors++;
            $display("FAIL b_restart_period got count=%0d last=%0d want 2 481", fs_cnt, fs_last);
        end
    endtask

    task automatic test_pipe0_c();
        int k, o, h, v, oh, ov, first_hi;
        logic ereq, vis, ehs, evs;
        logic [9:0] ex;
        logic [8:0] ergb;
        first_hi = -1;
        rst_c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({red_c, green_c, blue_c, hs_c, vs_c} !== {9'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL c_reset got rgb=%h hs=%b vs=%b want 0 0 0", {red_c, green_c, blue_c}, hs_c, vs_c);
        end
        @(negedge clk) rst_c = 1'b1;
        for (int n = 1; n <= 500; n++) begin
            @(posedge clk); #1;
            k = n - 1; h = k % 32; v = (k / 32) % 15;
            ereq = (h < 16) && (v < 8);
            ex = ereq ? 10'(h) : 10'd0;
            checks++;
            if ({ifc.req, ifc.x} !== {ereq, ex}) begin
                errors++;
                $display("FAIL c_request n=%0d got req=%b x=%0d want req=%b x=%0d", n, ifc.req, ifc.x, ereq, ex);
            end
            o = n - 2; oh = (o >= 0) ? o % 32 : 0; ov = (o >= 0) ? (o / 32) % 15 : 0;
            vis  = (o >= 0) && (oh < 16) && (ov < 8);
            ergb = vis ? {3'(oh % 8), 3'(ov % 8), 3'd3} : 9'd0;
            ehs  = (o >= 0) && (oh >= 20) && (oh < 26);
            evs  = (o >= 0) && (ov >= 10) && (ov < 12);
            checks++;
            if ({red_c, green_c, blue_c, hs_c, vs_c} !== {ergb, ehs, evs}) begin
                errors++;
                $display("FAIL c_pins n=%0d got rgb=%h hs=%b vs=%b want rgb=%h hs=%b vs=%b",
                         n, {red_c, green_c, blue_c}, hs_c, vs_c, ergb, ehs, evs);
            end
            if (hs_c === 1'b1 && first_hi < 0) first_hi = n;
        end
        checks++;
        if (first_hi != 22) begin
            errors++;
            $display("FAIL c_hsync_first_high got %0d want 22", first_hi);
        end
    endtask

    initial begin
        clk = 1'b0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        checks = 0;
        errors = 0;
        test_reset();
        test_line_a();
        test_frame_b();
        test_mid_reset_b();
        test_pipe0_c();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
